// File: rtl/demux_1_16_deser.sv
// Serial-to-parallel 1:16 demultiplexer: steers serial bits into slots (auto counter or
// external select) and publishes the assembled word with a one-cycle valid strobe.
module demux_1_16_deser #(
  parameter int unsigned Width = 16,
  parameter int unsigned SelW  = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic              in_bit_i,
  input  logic              addr_mode_i,
  input  logic [SelW-1:0]   sel_i,
  input  logic              flush_i,
  output logic [Width-1:0]  out_o,
  output logic              out_valid_o,
  output logic [SelW:0]     fill_count_o,
  output logic              busy_o
);

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e            state_q;
  logic              mode_q;
  logic [SelW-1:0]   cnt_q;
  logic [Width-1:0]  shadow_q;
  logic [Width-1:0]  mask_q;
  logic [SelW:0]     fill_q;
  logic [Width-1:0]  out_q;
  logic              out_valid_q;

  logic              cur_mode;
  logic [SelW-1:0]   slot;
  logic [Width-1:0]  merged;
  logic [Width-1:0]  mask_new;
  logic              slot_is_new;
  logic              word_done;

  // Mode is taken live from the input only on the first bit of a word.
  always_comb begin
    cur_mode    = (state_q == StIdle) ? addr_mode_i : mode_q;
    slot        = '0;
    if (cur_mode) begin
      slot = sel_i;
    end else if (state_q == StFill) begin
      slot = cnt_q;
    end
    merged       = shadow_q;
    merged[slot] = in_bit_i;
    mask_new       = mask_q;
    mask_new[slot] = 1'b1;
    slot_is_new = ~mask_q[slot];
    word_done   = &mask_new;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      shadow_q    <= '0;
      mask_q      <= '0;
      fill_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (flush_i) begin
        state_q  <= StIdle;
        cnt_q    <= '0;
        shadow_q <= '0;
        mask_q   <= '0;
        fill_q   <= '0;
      end else if (in_valid_i) begin
        if (word_done) begin
          out_q       <= merged;
          out_valid_q <= 1'b1;
          state_q     <= StIdle;
          cnt_q       <= '0;
          shadow_q    <= '0;
          mask_q      <= '0;
          fill_q      <= '0;
        end else begin
          if (state_q == StIdle) begin
            mode_q <= addr_mode_i;
          end
          state_q  <= StFill;
          cnt_q    <= slot + SelW'(1);
          shadow_q <= merged;
          mask_q   <= mask_new;
          if (slot_is_new) begin
            fill_q <= fill_q + (SelW + 1)'(1);
          end
        end
      end
    end
  end

  assign out_o        = out_q;
  assign out_valid_o  = out_valid_q;
  assign fill_count_o = fill_q;
  assign busy_o       = (state_q == StFill);

endmodule

// File: tb/tb_demux_1_16_deser.sv
// Randomized and directed bench for demux_1_16_deser against a word-level reference model.
module tb_demux_1_16_deser;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_bit;
  logic        addr_mode;
  logic [3:0]  sel;
  logic        flush;
  logic [15:0] out;
  logic        out_valid;
  logic [4:0]  fill_count;
  logic        busy;

  demux_1_16_deser dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_bit_i     (in_bit),
    .addr_mode_i  (addr_mode),
    .sel_i        (sel),
    .flush_i      (flush),
    .out_o        (out),
    .out_valid_o  (out_valid),
    .fill_count_o (fill_count),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_n    = 0;
  int pulse_cyc[$];

  // Reference model: a word being assembled plus a per-slot "already written" flag.
  logic [15:0] m_out, m_word;
  bit          m_filled[16];
  bit          m_active, m_mode, m_valid;
  int          m_pos;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 16; i++) c += m_filled[i];
    return c;
  endfunction

  function automatic void m_clear_partial();
    m_word   = '0;
    m_active = 1'b0;
    m_pos    = 0;
    for (int i = 0; i < 16; i++) m_filled[i] = 1'b0;
  endfunction

  function automatic void m_step(input bit r, f, v, b, m, input logic [3:0] s);
    int p;
    m_valid = 1'b0;
    if (r) begin
      m_clear_partial();
      m_out  = '0;
      m_mode = 1'b0;
    end else if (f) begin
      m_clear_partial();
    end else if (v) begin
      if (!m_active) begin
        m_active = 1'b1;
        m_mode   = m;
        m_pos    = 0;
      end
      p = m_mode ? int'(s) : m_pos;
      m_pos++;
      m_word[p]   = b;
      m_filled[p] = 1'b1;
      if (m_count() == 16) begin
        m_out   = m_word;
        m_valid = 1'b1;
        m_clear_partial();
      end
    end
  endfunction

  task automatic cyc(input bit r, f, v, b, m, input logic [3:0] s);
    rst = r; flush = f; in_valid = v; in_bit = b; addr_mode = m; sel = s;
    @(posedge clk);
    m_step(r, f, v, b, m, s);
    cyc_n++;
    #1;
    check("out", 32'(out), 32'(m_out));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("fill_count", 32'(fill_count), 32'(m_count()));
    check("busy", 32'(busy), 32'(m_active));
    if (out_valid) pulse_cyc.push_back(cyc_n);
  endtask

  task automatic idle(input int n, input bit m);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, m, 4'($urandom));
  endtask

  task automatic auto_bits(input logic [15:0] w, input int lo, input int hi, input bit m);
    for (int i = lo; i <= hi; i++) cyc(0, 0, 1, w[i], m, 4'($urandom));
  endtask

  logic [15:0] w;

  initial begin
    rst = 1; flush = 0; in_valid = 0; in_bit = 0; addr_mode = 0; sel = 0;
    m_out = '0; m_mode = 0; m_valid = 0;
    m_clear_partial();

    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("reset_out", 32'(out), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    // Auto-mode word.
    auto_bits(16'hFAC7, 0, 15, 0);
    check("auto_word", 32'(out), 32'hFAC7);
    check("auto_pulse", 32'(out_valid), 32'h1);
    idle(1, 0);
    check("auto_pulse_gone", 32'(out_valid), 32'h0);

    // Addressed mode, sel 15 down to 0.
    w = 16'hFAC7;
    for (int s = 15; s >= 0; s--) cyc(0, 0, 1, w[s], 1, 4'(s));
    check("addr_word", 32'(out), 32'hFAC7);
    // Duplicate write to slot 0: last write wins, count does not advance.
    cyc(0, 0, 1, 1, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
    check("dup_count", 32'(fill_count), 32'h1);
    for (int s = 1; s < 16; s++) cyc(0, 0, 1, w[s], 1, 4'(s));
    check("dup_word", 32'(out), 32'hFAC6);

    // Gap after bit 7 with addr_mode toggling; word stays in auto mode.
    auto_bits(16'hFAC7, 0, 7, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, i[0], 4'($urandom));
    check("gap_count", 32'(fill_count), 32'h8);
    auto_bits(16'hFAC7, 8, 15, 1);
    check("gap_word", 32'(out), 32'hFAC7);

    // Flush with simultaneous valid drops the bit and keeps out.
    auto_bits(16'h5555, 0, 8, 0);
    cyc(0, 1, 1, 1, 0, 0);
    check("flush_count", 32'(fill_count), 32'h0);
    check("flush_out", 32'(out), 32'hFAC7);
    check("flush_nopulse", 32'(out_valid), 32'h0);
    auto_bits(16'h1234, 0, 15, 0);
    check("after_flush_word", 32'(out), 32'h1234);

    // Reset mid-word.
    auto_bits(16'hFFFF, 0, 9, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("rst_mid_out", 32'(out), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    auto_bits(16'hA5A5, 0, 15, 0);
    check("after_rst_word", 32'(out), 32'hA5A5);

    // Back-to-back words with no bubble.
    pulse_cyc.delete();
    auto_bits(16'hFAC7, 0, 15, 0);
    check("b2b_first", 32'(out), 32'hFAC7);
    auto_bits(16'h0001, 0, 15, 0);
    check("b2b_second", 32'(out), 32'h0001);
    check("b2b_pulses", 32'(pulse_cyc.size()), 32'd2);
    if (pulse_cyc.size() == 2) check("b2b_gap", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd16);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
